// File: rtl/fu_issue_sched.sv
// ----------------------------------------------------------------------------
// fu_issue_sched
//
// Issue scheduler between the reservation station and the functional units.
// An RS_SIZE x RS_SIZE age matrix orders the RS entries by allocation time;
// each cycle at most one ready entry per FU class (ALU, MULT, LOAD, STORE) is
// granted, oldest first. MULT occupancy and the load/store port back-pressure
// gate their classes. Grants are combinational (same-cycle).
//
// FU class encoding of req_fu (FU_TYPE_W bits):
//   1 = ALU, 2 = MULT, 3 = LOAD, 4 = STORE; every other value is never granted.
//
// Ports:
//   clock          in   single clock, posedge
//   reset          in   synchronous, active-high; clears all state, gates outputs
//   alloc_en       in   RS_SIZE   one-hot/zero entry written by dispatch
//   req_ready      in   RS_SIZE   entry valid and operands ready
//   req_fu         in   RS_SIZE x FU_TYPE_W  FU class per entry
//   ld_port_ready  in   load unit accepts an issue
//   st_port_ready  in   store unit accepts an issue
//   squash         in   mispredict flush: kills grants, clears MULT occupancy
//   alu_grant      out  RS_SIZE   one-hot/zero
//   mult_grant     out  RS_SIZE   one-hot/zero
//   load_grant     out  RS_SIZE   one-hot/zero
//   store_grant    out  RS_SIZE   one-hot/zero
//   issue_any      out  OR of all grants
//   mult_busy      out  MULT occupancy counter non-zero
// ----------------------------------------------------------------------------
module fu_issue_sched #(
    parameter int unsigned RS_SIZE   = 8,
    parameter int unsigned MULT_LAT  = 4,
    parameter int unsigned FU_TYPE_W = 3
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [RS_SIZE-1:0]                  alloc_en,
    input  logic [RS_SIZE-1:0]                  req_ready,
    input  logic [RS_SIZE-1:0][FU_TYPE_W-1:0]   req_fu,
    input  logic                                ld_port_ready,
    input  logic                                st_port_ready,
    input  logic                                squash,
    output logic [RS_SIZE-1:0]                  alu_grant,
    output logic [RS_SIZE-1:0]                  mult_grant,
    output logic [RS_SIZE-1:0]                  load_grant,
    output logic [RS_SIZE-1:0]                  store_grant,
    output logic                                issue_any,
    output logic                                mult_busy
);

    localparam int unsigned CNT_W = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;
    localparam logic [CNT_W-1:0] MCNT_LOAD = CNT_W'(MULT_LAT - 1);

    localparam logic [FU_TYPE_W-1:0] FU_ALU   = FU_TYPE_W'(1);
    localparam logic [FU_TYPE_W-1:0] FU_MULT  = FU_TYPE_W'(2);
    localparam logic [FU_TYPE_W-1:0] FU_LOAD  = FU_TYPE_W'(3);
    localparam logic [FU_TYPE_W-1:0] FU_STORE = FU_TYPE_W'(4);

    // age_q[i][j] = 1: entry i is older than entry j
    logic [RS_SIZE-1:0][RS_SIZE-1:0] age_q, age_d;
    logic [CNT_W-1:0]                mcnt_q, mcnt_d;
    logic                            mcnt_nz;

    logic [RS_SIZE-1:0] base_elig;
    logic [RS_SIZE-1:0] elig_alu, elig_mult, elig_load, elig_store;
    logic [RS_SIZE-1:0] pick_alu, pick_mult, pick_load, pick_store;
    logic               grant_en;

    // Oldest-first pick. Entry i loses to an eligible j that is older, or that
    // is unordered against i and has the lower index.
    function automatic logic [RS_SIZE-1:0] pick_oldest(
        input logic [RS_SIZE-1:0]              elig,
        input logic [RS_SIZE-1:0][RS_SIZE-1:0] age_m
    );
        logic [RS_SIZE-1:0] win;
        win = elig;
        for (int i = 0; i < int'(RS_SIZE); i++) begin
            for (int j = 0; j < int'(RS_SIZE); j++) begin
                if (j != i && elig[j]) begin
                    if (age_m[j][i] || (!age_m[i][j] && j < i)) begin
                        win[i] = 1'b0;
                    end
                end
            end
        end
        return win;
    endfunction

    assign mcnt_nz = (mcnt_q != '0);

    // An entry written this cycle is masked; it becomes eligible next cycle.
    assign base_elig = req_ready & ~alloc_en;

    always_comb begin
        elig_alu   = '0;
        elig_mult  = '0;
        elig_load  = '0;
        elig_store = '0;
        for (int i = 0; i < int'(RS_SIZE); i++) begin
            elig_alu[i]   = base_elig[i] && (req_fu[i] == FU_ALU);
            elig_mult[i]  = base_elig[i] && (req_fu[i] == FU_MULT) && !mcnt_nz;
            elig_load[i]  = base_elig[i] && (req_fu[i] == FU_LOAD) && ld_port_ready;
            elig_store[i] = base_elig[i] && (req_fu[i] == FU_STORE) && st_port_ready;
        end
    end

    assign pick_alu   = pick_oldest(elig_alu, age_q);
    assign pick_mult  = pick_oldest(elig_mult, age_q);
    assign pick_load  = pick_oldest(elig_load, age_q);
    assign pick_store = pick_oldest(elig_store, age_q);

    assign grant_en    = !squash && !reset;
    assign alu_grant   = grant_en ? pick_alu   : '0;
    assign mult_grant  = grant_en ? pick_mult  : '0;
    assign load_grant  = grant_en ? pick_load  : '0;
    assign store_grant = grant_en ? pick_store : '0;
    assign issue_any   = |{alu_grant, mult_grant, load_grant, store_grant};
    assign mult_busy   = mcnt_nz && !reset;

    // Allocation clears row k and sets column k: entry k becomes the youngest.
    always_comb begin
        age_d = age_q;
        for (int i = 0; i < int'(RS_SIZE); i++) begin
            for (int j = 0; j < int'(RS_SIZE); j++) begin
                if (i == j) begin
                    age_d[i][j] = 1'b0;
                end else if (alloc_en[i]) begin
                    age_d[i][j] = 1'b0;
                end else if (alloc_en[j]) begin
                    age_d[i][j] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        mcnt_d = mcnt_q;
        if (squash) begin
            mcnt_d = '0;
        end else if (|mult_grant) begin
            mcnt_d = MCNT_LOAD;
        end else if (mcnt_nz) begin
            mcnt_d = mcnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            age_q  <= '0;
            mcnt_q <= '0;
        end else begin
            age_q  <= age_d;
            mcnt_q <= mcnt_d;
        end
    end

endmodule

// File: tb/tb_fu_issue_sched.sv
module tb_fu_issue_sched;

    localparam logic [2:0] FU_NONE  = 3'd0;
    localparam logic [2:0] FU_ALU   = 3'd1;
    localparam logic [2:0] FU_MULT  = 3'd2;
    localparam logic [2:0] FU_LOAD  = 3'd3;
    localparam logic [2:0] FU_STORE = 3'd4;
    localparam logic [2:0] FU_BAD   = 3'd7;

    logic             clock;
    logic             reset;
    logic [7:0]       alloc_en;
    logic [7:0]       req_ready;
    logic [7:0][2:0]  req_fu;
    logic             ld_port_ready;
    logic             st_port_ready;
    logic             squash;
    logic [7:0]       alu_grant;
    logic [7:0]       mult_grant;
    logic [7:0]       load_grant;
    logic [7:0]       store_grant;
    logic             issue_any;
    logic             mult_busy;

    int checks = 0;
    int errors = 0;

    fu_issue_sched #(
        .RS_SIZE   (8),
        .MULT_LAT  (4),
        .FU_TYPE_W (3)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .alloc_en      (alloc_en),
        .req_ready     (req_ready),
        .req_fu        (req_fu),
        .ld_port_ready (ld_port_ready),
        .st_port_ready (st_port_ready),
        .squash        (squash),
        .alu_grant     (alu_grant),
        .mult_grant    (mult_grant),
        .load_grant    (load_grant),
        .store_grant   (store_grant),
        .issue_any     (issue_any),
        .mult_busy     (mult_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance past the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Let combinational outputs settle (still well before the falling edge).
    task automatic settle();
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_grants(input string tag, input logic [7:0] a, input logic [7:0] m,
                              input logic [7:0] l, input logic [7:0] s);
        chk({tag, ".alu"},   32'(alu_grant),   32'(a));
        chk({tag, ".mult"},  32'(mult_grant),  32'(m));
        chk({tag, ".load"},  32'(load_grant),  32'(l));
        chk({tag, ".store"}, 32'(store_grant), 32'(s));
        chk({tag, ".any"},   32'(issue_any),   32'(|{a, m, l, s}));
    endtask

    initial begin
        reset         = 1'b1;
        alloc_en      = '0;
        req_ready     = '0;
        req_fu        = '0;
        ld_port_ready = 1'b1;
        st_port_ready = 1'b1;
        squash        = 1'b0;
        tick();
        // Reset held: requests present but everything must stay 0.
        for (int i = 0; i < 8; i++) req_fu[i] = FU_ALU;
        req_ready = 8'hFF;
        settle();
        chk_grants("reset_hold", 8'h00, 8'h00, 8'h00, 8'h00);
        chk("reset_hold.busy", 32'(mult_busy), 32'd0);
        tick();
        reset     = 1'b0;
        req_ready = '0;
        for (int i = 0; i < 8; i++) req_fu[i] = FU_NONE;

        // Oldest-first ALU: alloc 5, 2, 7.
        req_fu[5] = FU_ALU; req_fu[2] = FU_ALU; req_fu[7] = FU_ALU;
        alloc_en = 8'h20; tick();
        alloc_en = 8'h04; tick();
        alloc_en = 8'h80; tick();
        alloc_en = 8'h00;
        req_ready = 8'hA4;
        settle();
        chk_grants("oldest_first", 8'h20, 8'h00, 8'h00, 8'h00);
        tick();
        req_ready = 8'h84;
        settle();
        chk("oldest_second", 32'(alu_grant), 32'h04);
        tick();
        req_ready = 8'h80;
        settle();
        chk("oldest_third", 32'(alu_grant), 32'h80);
        tick();

        // Parallel classes.
        req_fu[1] = FU_ALU; req_fu[3] = FU_MULT; req_fu[4] = FU_LOAD; req_fu[6] = FU_STORE;
        req_ready = 8'h5A;
        settle();
        chk_grants("parallel", 8'h02, 8'h08, 8'h10, 8'h40);
        tick();
        req_ready = 8'h00;
        settle();
        chk("parallel_busy", 32'(mult_busy), 32'd1);
        tick(); tick(); tick();
        settle();
        chk("parallel_idle", 32'(mult_busy), 32'd0);

        // MULT occupancy, MULT_LAT = 4: unordered entries 0 and 1, low index wins.
        req_fu[0] = FU_MULT; req_fu[1] = FU_MULT;
        req_ready = 8'h03;
        settle();
        chk("mult_t0", 32'(mult_grant), 32'h01);
        tick();
        req_ready = 8'h02;
        for (int k = 1; k <= 3; k++) begin
            settle();
            chk($sformatf("mult_t%0d.grant", k), 32'(mult_grant), 32'h00);
            chk($sformatf("mult_t%0d.busy", k), 32'(mult_busy), 32'd1);
            tick();
        end
        settle();
        chk("mult_t4.grant", 32'(mult_grant), 32'h02);
        chk("mult_t4.busy", 32'(mult_busy), 32'd0);
        tick();
        req_ready = 8'h00;
        tick(); tick(); tick();

        // Load port back-pressure.
        ld_port_ready = 1'b0;
        req_ready = 8'h10;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk($sformatf("ld_block%0d", k), 32'(load_grant), 32'h00);
            tick();
        end
        ld_port_ready = 1'b1;
        settle();
        chk("ld_release", 32'(load_grant), 32'h10);
        tick();

        // Store port back-pressure.
        st_port_ready = 1'b0;
        req_ready = 8'h40;
        settle();
        chk("st_block", 32'(store_grant), 32'h00);
        tick();
        st_port_ready = 1'b1;
        settle();
        chk("st_release", 32'(store_grant), 32'h40);
        tick();

        // Unmapped FU value is never granted.
        req_fu[3] = FU_BAD;
        req_ready = 8'h08;
        settle();
        chk_grants("unmapped", 8'h00, 8'h00, 8'h00, 8'h00);
        tick();

        // Squash after a MULT grant.
        req_fu[2] = FU_ALU;
        req_ready = 8'h01;
        settle();
        chk("squash_t0", 32'(mult_grant), 32'h01);
        tick();
        squash = 1'b1;
        req_ready = 8'h06;
        settle();
        chk_grants("squash_t1", 8'h00, 8'h00, 8'h00, 8'h00);
        tick();
        squash = 1'b0;
        req_ready = 8'h02;
        settle();
        chk("squash_t2.busy", 32'(mult_busy), 32'd0);
        chk("squash_t2.grant", 32'(mult_grant), 32'h02);
        tick();

        // Reset while mcnt = 3; then tie-break by index with a clean matrix.
        reset = 1'b1;
        req_fu[6] = FU_ALU; req_fu[1] = FU_ALU; req_fu[3] = FU_MULT;
        req_ready = 8'h4A;
        settle();
        chk_grants("reset_mid", 8'h00, 8'h00, 8'h00, 8'h00);
        chk("reset_mid.busy", 32'(mult_busy), 32'd0);
        tick();
        reset = 1'b0;
        settle();
        chk("post_reset.alu", 32'(alu_grant), 32'h02);
        chk("post_reset.mult", 32'(mult_grant), 32'h08);
        chk("post_reset.busy", 32'(mult_busy), 32'd0);
        tick();

        // Same-entry alloc and request: masked, then youngest.
        for (int i = 0; i < 8; i++) req_fu[i] = FU_ALU;
        alloc_en = 8'h04;
        req_ready = 8'h04;
        settle();
        chk("alloc_mask", 32'(alu_grant), 32'h00);
        tick();
        alloc_en = 8'h00;
        req_ready = 8'h24;
        settle();
        chk("alloc_youngest", 32'(alu_grant), 32'h20);
        tick();
        // Alloc of entry 0 alongside a grant: grant uses the old matrix.
        alloc_en = 8'h01;
        settle();
        chk("alloc_and_grant", 32'(alu_grant), 32'h20);
        tick();
        alloc_en = 8'h00;
        req_ready = 8'h25;
        settle();
        chk("after_alloc0", 32'(alu_grant), 32'h20);
        tick();
        req_ready = 8'h05;
        settle();
        chk("two_over_zero", 32'(alu_grant), 32'h04);
        tick();
        // Re-allocate entry 2: it becomes younger than entry 0.
        alloc_en = 8'h04;
        req_ready = 8'h01;
        settle();
        chk("realloc_cycle", 32'(alu_grant), 32'h01);
        tick();
        alloc_en = 8'h00;
        req_ready = 8'h05;
        settle();
        chk("realloc_youngest", 32'(alu_grant), 32'h01);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
